mac_result_stage: RTL
=====================

Name: mac_result_stage

Overview:
- Downstream neighbour of the MAC: captures each accumulated MAC result on its load strobe and converts it from the MAC fixed-point format to the engine output format (shift, optional rounding, saturation).
- Buffers converted words in a small synchronous FIFO and presents them to the next engine stage over a valid/ready handshake.
- Reports sticky saturation and overflow (dropped-result) status.

Parameters:
- DATA_WIDTH, 32, MAC result width, signed, FRAC_IN fraction bits.
- FRAC_IN, 16, fraction bits of the MAC result.
- OUT_WIDTH, 16, output word width, signed.
- FRAC_OUT, 8, fraction bits of the output; FRAC_IN >= FRAC_OUT and OUT_WIDTH <= DATA_WIDTH, else elaboration error.
- ADDR_LINES, 2, FIFO depth = 2**ADDR_LINES.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- res_i  in  DATA_WIDTH  MAC result, sampled when res_ld_i=1.
- res_ld_i  in  1  one-cycle load strobe from the MAC controller.
- clear_i  in  1  synchronous clear: flushes pipeline, FIFO and sticky flags.
- data_o  out  OUT_WIDTH  converted word at FIFO head.
- valid_o  out  1  data_o valid.
- ready_i  in  1  consumer accepts data_o when valid_o and ready_i are both 1.
- count_o  out  ADDR_LINES+1  FIFO occupancy.
- sat_o  out  1  sticky: some result saturated.
- ovf_o  out  1  sticky: some result dropped because the FIFO was full.

Behaviour:
- Reset (async, rstn_i=0): all outputs 0, pipeline valids 0, FIFO pointers 0, sticky flags 0.
- Stage S1, cycle after res_ld_i:
  - Register res_i and the valid bit.
  - SH = FRAC_IN-FRAC_OUT.
  - Arithmetic right shift by SH, computed in DATA_WIDTH+1 bits so the rounding add cannot wrap.
- Stage S2, next cycle: saturate to OUT_WIDTH signed.
  - Above max -> 2**(OUT_WIDTH-1)-1.
  - Below min -> -2**(OUT_WIDTH-1).
  - Either case sets sat_o on the same edge as the FIFO write.
- FIFO write: at the end of S2, i.e. res_ld_i at edge N -> FIFO write at edge N+2 -> valid_o=1 at N+2 when the FIFO was empty.
- FIFO read: pop on valid_o&&ready_i.
  - data_o is driven from the head register (registered output, no combinational path ready_i->data_o).
  - valid_o = (count_o != 0).
- Throughput: one result per cycle; back-to-back res_ld_i allowed.
- Full FIFO plus S2 write without a simultaneous pop: word dropped, ovf_o set, FIFO contents unchanged.
- Full FIFO with a simultaneous pop: write succeeds, count_o unchanged.
- Empty FIFO with a simultaneous write and ready_i: no pop that cycle (valid_o was 0); the word appears next cycle.
- Pointers wrap modulo 2**ADDR_LINES; the extra count bit distinguishes full from empty.
- clear_i=1 at an edge:
  - S1/S2 valids, pointers, count_o, sat_o and ovf_o go to 0.
  - A res_ld_i in the same cycle is discarded.
  - clear_i has priority over push and pop.
- Reset asserted mid-operation: immediate return to reset state; in-flight words are lost.
- Sticky flags clear only on reset or clear_i.

Optional Feature:
- Macro: NLA_RESULT_ROUND_EN.
- Defined:
  - S1 adds 1<<(SH-1) before the shift (round half up toward +inf).
  - When SH==0 no add is performed.
  - Rounding overflow is caught by S2 saturation.
- Undefined: plain truncation (floor). Latency is identical either way.

Decomposition:
- Shared package nla_pkg holds:
  - default width constants (DATA_WIDTH, FRAC_IN, OUT_WIDTH, FRAC_OUT);
  - function sat_trunc(value, width) returning the saturated word and a saturation flag;
  - localparam SH derivation.
- One natural sub-module: result_fifo (synchronous FIFO with count, registered head, full/empty). It is distinct from the BRAM FIFOs because it needs a same-cycle push/pop at full.

Test Plan (defaults: DATA_WIDTH=32, FRAC_IN=16, OUT_WIDTH=16, FRAC_OUT=8, ADDR_LINES=2):
- res_i=0x00018000 (1.5) pulsed with ready_i=1 -> data_o=0x0180 and valid_o=1 exactly 2 edges after the strobe; sat_o=0.
- res_i=0x00000080 -> data_o=0x0001 with NLA_RESULT_ROUND_EN, 0x0000 without.
- res_i=0x7FFF0000 -> data_o=0x7FFF, sat_o=1.
  - res_i=0x80000000 -> 0x8000.
  - res_i=0xFFFF0000 -> 0xFF00, no saturation.
- ready_i=0, 5 back-to-back strobes with values 1..5 (as Q16.16) -> count_o=4, ovf_o=1; then ready_i=1 -> pops 0x0100,0x0200,0x0300,0x0400 in order, valid_o then 0.
- FIFO full with ready_i=1 and a simultaneous S2 write -> count_o stays 4, ovf_o stays 0, order preserved.
- Fill 3 words with sat_o=1, then clear_i one cycle with res_ld_i also high -> count_o=0, valid_o=0, sat_o=0, ovf_o=0, no word emerges. Repeat with rstn_i asserted mid-stream -> same result asynchronously.

Source files
------------

// File: rtl/nla_pkg.sv
// Shared constants and helpers for the result path: default widths, shift derivation, saturation.
package nla_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FRAC_IN    = 16;
    localparam int DEF_OUT_WIDTH  = 16;
    localparam int DEF_FRAC_OUT   = 8;
    localparam int DEF_ADDR_LINES = 2;

    // Widest value sat_trunc can accept; callers sign-extend into it.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] word;
        logic                    sat;
    } sat_res_t;

    function automatic int shift_amount(input int frac_in, input int frac_out);
        return frac_in - frac_out;
    endfunction

    localparam int DEF_SH = shift_amount(DEF_FRAC_IN, DEF_FRAC_OUT);

    // Clamp a signed value into a 'width'-bit signed range; the word stays sign-extended.
    function automatic sat_res_t sat_trunc(input logic signed [SAT_W-1:0] value, input int width);
        sat_res_t                r;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v  = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v  = -max_v - 64'sd1;
        r.word = value;
        r.sat  = 1'b0;
        if (value > max_v) begin
            r.word = max_v;
            r.sat  = 1'b1;
        end else if (value < min_v) begin
            r.word = min_v;
            r.sat  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO with occupancy count and a registered head word.
// Accepts a push while full when a pop happens in the same cycle.
module result_fifo
    import nla_pkg::*;
#(
    parameter int WIDTH      = DEF_OUT_WIDTH,
    parameter int ADDR_LINES = DEF_ADDR_LINES
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic [ADDR_LINES:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int DEPTH = 2 ** ADDR_LINES;
    localparam logic [ADDR_LINES:0] FULL_CNT = (ADDR_LINES + 1)'(DEPTH);
    localparam logic [ADDR_LINES:0] ONE_CNT  = (ADDR_LINES + 1)'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_LINES-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_LINES-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_LINES-1:0] rd_next;
    logic [ADDR_LINES:0]   count_q, count_d;
    logic [WIDTH-1:0]      head_q, head_d;
    logic                  pop_ok;
    logic                  push_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = head_q;

    always_comb begin
        pop_ok   = pop_i && !empty_o && !clear_i;
        push_ok  = push_i && (!full_o || pop_ok) && !clear_i;
        rd_next  = rd_ptr_q + ADDR_LINES'(1);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        count_d  = count_q + (ADDR_LINES + 1)'(push_ok) - (ADDR_LINES + 1)'(pop_ok);

        if (pop_ok) begin
            rd_ptr_d = rd_next;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_LINES'(1);
        end

        // The head comes straight from the write port when the FIFO is (about to be) empty,
        // otherwise from the next stored entry, so data_o never depends on ready.
        if (push_ok && (empty_o || (pop_ok && count_q == ONE_CNT))) begin
            head_d = wdata_i;
        end else if (pop_ok) begin
            head_d = mem_q[rd_next];
        end

        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mac_result_stage.sv
// MAC result capture, fixed-point conversion (shift, saturate) and output FIFO with sticky status.
// Build option: define NLA_RESULT_ROUND_EN to round half up instead of truncating.
module mac_result_stage
    import nla_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_IN    = DEF_FRAC_IN,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int FRAC_OUT   = DEF_FRAC_OUT,
    parameter int ADDR_LINES = DEF_ADDR_LINES
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] res_i,
    input  logic                  res_ld_i,
    input  logic                  clear_i,
    output logic [OUT_WIDTH-1:0]  data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [ADDR_LINES:0]   count_o,
    output logic                  sat_o,
    output logic                  ovf_o
);

    localparam int SH = shift_amount(FRAC_IN, FRAC_OUT);

    if (FRAC_IN < FRAC_OUT || OUT_WIDTH > DATA_WIDTH || DATA_WIDTH >= SAT_W || ADDR_LINES < 1)
    begin : g_param_check
        $error("mac_result_stage: illegal parameter combination");
    end

`ifdef NLA_RESULT_ROUND_EN
    localparam int RND_POS = (SH > 0) ? SH - 1 : 0;
    // Half an output LSB; zero when there is nothing to shift out.
    localparam logic signed [DATA_WIDTH:0] RND_ADD = (DATA_WIDTH + 1)'(SH > 0) << RND_POS;
`endif

    // One extra bit of headroom keeps the rounding add from wrapping at the positive limit.
    function automatic logic signed [DATA_WIDTH:0] shift_round(input logic signed [DATA_WIDTH-1:0] v);
        logic signed [DATA_WIDTH:0] ext;
        ext = {v[DATA_WIDTH-1], v};
`ifdef NLA_RESULT_ROUND_EN
        ext = ext + RND_ADD;
`endif
        return ext >>> SH;
    endfunction

    logic signed [DATA_WIDTH-1:0] res_p1_q, res_p1_d;
    logic                         vld_p1_q, vld_p1_d;
    logic signed [DATA_WIDTH:0]   res_p2_q, res_p2_d;
    logic                         vld_p2_q, vld_p2_d;
    logic                         sat_q, sat_d;
    logic                         ovf_q, ovf_d;
    sat_res_t                     sat_p2;
    logic [OUT_WIDTH-1:0]         word_p2;
    logic                         sat_word_unused;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic                         fifo_full;
    logic                         fifo_empty;

    always_comb begin
        // S1: capture
        vld_p1_d = res_ld_i && !clear_i;
        res_p1_d = res_ld_i ? res_i : res_p1_q;

        // S1 -> S2: shift (and optional round)
        vld_p2_d = vld_p1_q && !clear_i;
        res_p2_d = vld_p1_q ? shift_round(res_p1_q) : res_p2_q;

        // S2 -> FIFO: saturate and write
        sat_p2          = sat_trunc(SAT_W'(res_p2_q), OUT_WIDTH);
        word_p2         = sat_p2.word[OUT_WIDTH-1:0];
        sat_word_unused = ^sat_p2.word[SAT_W-1:OUT_WIDTH];
        fifo_push       = vld_p2_q && !clear_i;
        fifo_pop        = ready_i && !fifo_empty;

        sat_d = sat_q || (vld_p2_q && sat_p2.sat);
        ovf_d = ovf_q || (fifo_push && fifo_full && !fifo_pop);
        if (clear_i) begin
            sat_d = 1'b0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            sat_q    <= sat_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        res_p1_q <= res_p1_d;
        res_p2_q <= res_p2_d;
    end

    result_fifo #(
        .WIDTH      (OUT_WIDTH),
        .ADDR_LINES (ADDR_LINES)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clear_i (clear_i),
        .push_i  (fifo_push),
        .wdata_i (word_p2),
        .pop_i   (fifo_pop),
        .rdata_o (data_o),
        .count_o (count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign valid_o = !fifo_empty;
    assign sat_o   = sat_q;
    assign ovf_o   = ovf_q;

endmodule
